// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, issues instruction-memory reads for
// legal addresses, and presents one registered instruction (or a nop with an
// exception flag) to decode until it is consumed.
//
// Handshake: imem_req is asserted combinationally while in FETCH with a legal
// PC, and imem_addr always mirrors PC. A read completes on any cycle where
// imem_req and imem_ack are both high; imem_ack with imem_req low is ignored.
// Towards decode, Instr/PC are valid while instr_valid is high. They are
// consumed on a cycle with instr_valid and en both high, and en has no effect
// while instr_valid is low.
module ifu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC,
  parameter logic [3:0]  TIMEOUT  = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        exc_adel,
  output logic        exc_bus,
  output logic        o_dbg_state   // 0 = FETCH, 1 = VALID
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_adel;
  logic        r_bus;
  logic [3:0]  r_cnt;

  logic        w_pc_legal;
  logic        w_req;
  logic [3:0]  w_cnt_inc;

  // Address legality, request generation and the incremented wait count.
  always_comb begin
    w_pc_legal = (r_pc[1:0] == 2'b00) && (r_pc >= IM_LO) && (r_pc <= IM_HI);
    w_req      = (r_state == S_FETCH) && w_pc_legal;
    w_cnt_inc  = r_cnt + 4'd1;
  end

  // Fetch FSM: the bus error fires on the cycle the count would reach
  // TIMEOUT, giving exactly TIMEOUT request cycles; an ack on that cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
      r_bus   <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!w_pc_legal) begin
            r_instr <= 32'h0;
            r_adel  <= 1'b1;
            r_bus   <= 1'b0;
            r_valid <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= S_VALID;
          end else if (imem_ack) begin
            r_instr <= imem_rdata;
            r_adel  <= 1'b0;
            r_bus   <= 1'b0;
            r_valid <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= S_VALID;
          end else if (w_cnt_inc == TIMEOUT) begin
            r_instr <= 32'h0;
            r_adel  <= 1'b0;
            r_bus   <= 1'b1;
            r_valid <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= S_VALID;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_VALID: begin
          if (en) begin
            r_pc    <= next_PC;
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
            r_bus   <= 1'b0;
            r_cnt   <= 4'd0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Output wiring.
  always_comb begin
    imem_req    = w_req;
    imem_addr   = r_pc;
    PC          = r_pc;
    Instr       = r_instr;
    instr_valid = r_valid;
    exc_adel    = r_adel;
    exc_bus     = r_bus;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: cycle-by-cycle vector table plus hand sequences for timeout,
// ack-at-last-cycle and reset during a pending fetch.
module tb_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_PC;
  logic        en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        exc_adel;
  logic        exc_bus;
  logic        o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ifu dut (
    .clk         (clk),
    .reset       (reset),
    .next_PC     (next_PC),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PC          (PC),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .exc_adel    (exc_adel),
    .exc_bus     (exc_bus),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic        a;
    logic        b;
  } vec_t;

  vec_t vt[22];

  // Drive inputs for one cycle (called just after a rising edge) and move to
  // the falling edge, where outputs are sampled.
  task automatic drive(input logic rst, input logic e, input logic [31:0] npc,
                       input logic ack, input logic [31:0] rdata);
    reset      = rst;
    en         = e;
    next_PC    = npc;
    imem_ack   = ack;
    imem_rdata = rdata;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic req, input logic [31:0] pc,
                       input logic [31:0] instr, input logic v, input logic a,
                       input logic b);
    n_vec++;
    if (imem_req !== req || imem_addr !== pc || PC !== pc || Instr !== instr ||
        instr_valid !== v || exc_adel !== a || exc_bus !== b ||
        o_dbg_state !== v) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h pc=%h instr=%h v=%b adel=%b bus=%b st=%b, exp req=%b pc=%h instr=%h v=%b adel=%b bus=%b",
               name, imem_req, imem_addr, PC, Instr, instr_valid, exc_adel,
               exc_bus, o_dbg_state, req, pc, instr, v, a, b);
    end
  endtask

  initial begin
    // rst en npc ack rdata | req pc instr v adel bus
    vt[0]  = '{0,0,32'h0,      1,32'h3C01_1234, 1,32'h3000,32'h0,         0,0,0};
    vt[1]  = '{0,0,32'h0,      1,32'hFFFF_FFFF, 0,32'h3000,32'h3C01_1234, 1,0,0};
    vt[2]  = '{0,1,32'h3004,   0,32'h0,         0,32'h3000,32'h3C01_1234, 1,0,0};
    vt[3]  = '{0,1,32'h5000,   0,32'h0,         1,32'h3004,32'h3C01_1234, 0,0,0};
    vt[4]  = '{0,1,32'h5000,   0,32'h0,         1,32'h3004,32'h3C01_1234, 0,0,0};
    vt[5]  = '{0,0,32'h0,      1,32'h2402_0005, 1,32'h3004,32'h3C01_1234, 0,0,0};
    vt[6]  = '{0,1,32'h3006,   0,32'h0,         0,32'h3004,32'h2402_0005, 1,0,0};
    vt[7]  = '{0,1,32'h3008,   1,32'hDEAD_BEEF, 0,32'h3006,32'h2402_0005, 0,0,0};
    vt[8]  = '{0,1,32'h3008,   0,32'h0,         0,32'h3006,32'h0,         1,1,0};
    vt[9]  = '{0,0,32'h0,      1,32'h1111_1111, 1,32'h3008,32'h0,         0,0,0};
    vt[10] = '{0,1,32'h7000,   0,32'h0,         0,32'h3008,32'h1111_1111, 1,0,0};
    vt[11] = '{0,0,32'h0,      1,32'h2222_2222, 0,32'h7000,32'h1111_1111, 0,0,0};
    vt[12] = '{0,1,32'h6FFC,   0,32'h0,         0,32'h7000,32'h0,         1,1,0};
    vt[13] = '{0,0,32'h0,      1,32'h6FFC_0001, 1,32'h6FFC,32'h0,         0,0,0};
    vt[14] = '{0,1,32'h2FFC,   0,32'h0,         0,32'h6FFC,32'h6FFC_0001, 1,0,0};
    vt[15] = '{0,0,32'h0,      0,32'h0,         0,32'h2FFC,32'h6FFC_0001, 0,0,0};
    vt[16] = '{0,1,32'h3000,   0,32'h0,         0,32'h2FFC,32'h0,         1,1,0};
    vt[17] = '{0,1,32'h3004,   1,32'hAAAA_0001, 1,32'h3000,32'h0,         0,0,0};
    vt[18] = '{0,1,32'h3004,   1,32'h0,         0,32'h3000,32'hAAAA_0001, 1,0,0};
    vt[19] = '{0,1,32'h3008,   1,32'hBBBB_0002, 1,32'h3004,32'hAAAA_0001, 0,0,0};
    vt[20] = '{0,1,32'h3008,   0,32'h0,         0,32'h3004,32'hBBBB_0002, 1,0,0};
    vt[21] = '{0,0,32'h0,      1,32'hC0DE_000C, 1,32'h3008,32'hBBBB_0002, 0,0,0};

    // Reset for two edges with distracting inputs
    reset = 1'b1; en = 1'b1; next_PC = 32'h4000; imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(posedge clk); @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h4000, 1'b1, 32'h1234_5678);
    check("reset_state", 1'b1, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].npc, vt[i].ack, vt[i].rdata);
      check($sformatf("vec%0d", i), vt[i].req, vt[i].pc, vt[i].instr,
            vt[i].v, vt[i].a, vt[i].b);
      next_cycle();
    end

    // Timeout: exactly 15 request cycles, then bus error with nop
    drive(1'b0, 1'b1, 32'h3010, 1'b0, 32'h0);
    check("to_enter", 1'b0, 32'h3008, 32'hC0DE_000C, 1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 32'h5000, 1'b0, 32'h0);
      check($sformatf("to_wait%0d", i), 1'b1, 32'h3010, 32'hC0DE_000C,
            1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_9999);
    check("to_buserr", 1'b0, 32'h3010, 32'h0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 1'b1, 32'h3014, 1'b0, 32'h0);
    check("to_hold", 1'b0, 32'h3010, 32'h0, 1'b1, 1'b0, 1'b1);
    next_cycle();

    // Ack on the 15th request cycle: normal fetch, no bus error
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check($sformatf("late_wait%0d", i), 1'b1, 32'h3014, 32'h0,
            1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D);
    check("late_ack_cycle", 1'b1, 32'h3014, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 32'h3020, 1'b0, 32'h0);
    check("late_ack_done", 1'b0, 32'h3014, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Reset during cycle 2 of a pending fetch with ack high
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_mid_c1", 1'b1, 32'h3020, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 32'h4444, 1'b1, 32'hDEAD_BEEF);
    check("rst_mid_c2", 1'b1, 32'h3020, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_mid_after", 1'b1, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3C01_1234);
    check("rst_refetch", 1'b1, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_refetch_done", 1'b0, 32'h3000, 32'h3C01_1234, 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, PC value loaded by reset.
REQ-002 Parameter IM_LO, 32'h0000_3000, lowest legal fetch address.
REQ-003 Parameter IM_HI, 32'h0000_6FFC, highest legal fetch address.
REQ-004 Parameter TIMEOUT, 4'd15, max wait cycles for imem_ack before bus error.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 next_PC  input  32  next fetch address from the next-PC stage.
REQ-008 en  input  1  advance request: consume current instruction, load next_PC.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  read address, always equal to PC.
REQ-011 imem_ack  input  1  read data valid this cycle.
REQ-012 imem_rdata  input  32  read data, sampled only when imem_req and imem_ack both high.
REQ-013 PC  output  32  address of current/pending instruction.
REQ-014 Instr  output  32  fetched instruction, registered.
REQ-015 instr_valid  output  1  Instr/PC pair valid for decode.
REQ-016 exc_adel  output  1  fetch address misaligned or outside [IM_LO, IM_HI].
REQ-017 exc_bus  output  1  fetch timed out.

Function
REQ-018 FSM has two states: FETCH (request outstanding), VALID (instruction held).
REQ-019 imem_req SHALL be combinational: high iff state==FETCH and PC legal (PC[1:0]==0, IM_LO<=PC<=IM_HI, unsigned).
REQ-020 FETCH, legal PC, imem_ack=1: Instr<=imem_rdata, instr_valid<=1, exc flags<=0, wait counter<=0, go VALID.
REQ-021 FETCH, legal PC, imem_ack=0: wait counter +1; when counter==TIMEOUT with no ack, Instr<=0, exc_bus<=1, instr_valid<=1, go VALID.
REQ-022 Ack on the same cycle the counter equals TIMEOUT: ack wins, no exc_bus.
REQ-023 FETCH, illegal PC: no request issued; next edge Instr<=0 (nop), exc_adel<=1, instr_valid<=1, go VALID.
REQ-024 en SHALL be ignored in FETCH; PC never changes while a request is outstanding.
REQ-025 VALID, en=1: PC<=next_PC, instr_valid<=0, exc flags<=0, counter<=0, go FETCH.
REQ-026 VALID, en=0: all registers hold; instr_valid stays 1 indefinitely.
REQ-027 imem_ack while imem_req=0 SHALL be ignored.
REQ-028 Minimum fetch latency: ack in first FETCH cycle -> instr_valid high one cycle after PC load.
REQ-029 Back-to-back throughput with ack every request and en held high: one instruction per two cycles.
REQ-030 next_PC is captured unmodified (no alignment masking); legality judged only in FETCH.
REQ-031 Wait counter 4 bits wide, saturating never required (cleared on exit from FETCH).

Reset
REQ-032 reset=1 at an edge: PC<=PC_RESET, Instr<=0, instr_valid<=0, exc_adel<=0, exc_bus<=0, counter<=0, state<=FETCH.
REQ-033 reset SHALL override ack, en and timeout in the same cycle, including mid-request.
REQ-034 First request issues in the cycle after reset deasserts, address PC_RESET.

Verification
REQ-035 Reset, imem_ack=1 with rdata 32'h3C01_1234 -> next edge instr_valid=1, PC=32'h3000, Instr=32'h3C01_1234.
REQ-036 VALID, en=1, next_PC=32'h3004, ack delayed 3 cycles -> imem_req high 3 cycles at addr 32'h3004, then Instr updates, en during wait ignored.
REQ-037 next_PC=32'h3006 -> no imem_req; next edge exc_adel=1, Instr=0, instr_valid=1; en then next_PC=32'h3008 clears exc_adel.
REQ-038 next_PC=32'h7000 -> exc_adel=1, imem_req never asserted for that PC.
REQ-039 imem_ack held 0 -> exactly TIMEOUT=15 request cycles, then exc_bus=1, Instr=0; ack at cycle 15 instead -> normal fetch, exc_bus=0.
REQ-040 reset asserted during cycle 2 of a pending fetch with ack=1 -> PC=32'h3000, instr_valid=0, rdata discarded.
